// File: rtl/parity_encoder.sv
// Even-parity encoder with a two-entry skid buffer: out_word = {^data, data}.
// Optional define PARITY_ERR_INJECT_EN adds inject_err to flip stored parity.
module parity_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH:0]   out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
`ifdef PARITY_ERR_INJECT_EN
  input  logic                  inject_err,
`endif
  output logic [1:0]            state_dbg
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never depends on ready, and ready is register-only.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  rst_done;
  logic [DATA_WIDTH:0]   head_q, tail_q;
  logic [DATA_WIDTH:0]   enc_word;
  logic                  flip;
  logic                  accept, emit;
  logic                  load_head_in, load_head_tail, load_tail;

`ifdef PARITY_ERR_INJECT_EN
  assign flip = inject_err;
`else
  assign flip = 1'b0;
`endif

  assign enc_word  = {(^in_data) ^ flip, in_data};
  assign in_ready  = rst_done && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign out_word  = head_q;
  assign state_dbg = state;

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_tail = 1'b1;
        end else if (emit) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain into head can occur
        if (emit) begin
          state_nxt      = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= EMPTY;
      rst_done <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      if (load_head_in)   head_q <= enc_word;
      if (load_head_tail) head_q <= tail_q;
      if (load_tail)      tail_q <= enc_word;
      if (emit)           word_cnt <= word_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule
